// File: rtl/dmem_pkg.sv
// Shared types and helpers for the parametrised data memory.
package dmem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } dmem_state_e;

    // Fill patterns selectable through INIT_MODE.
    localparam int INIT_INDEX = 0;
    localparam int INIT_ZERO  = 1;

    // Widest word the strobe merge handles. Callers zero-extend to this
    // width and keep only their own DATA_WIDTH bits of the result.
    localparam int DMEM_MAX_W = 128;
    localparam int DMEM_MAX_B = DMEM_MAX_W / 8;

    // Byte k of the result comes from new_w when be[k] is set, else from old_w.
    function automatic logic [DMEM_MAX_W-1:0] byte_merge(
        input logic [DMEM_MAX_W-1:0] old_w,
        input logic [DMEM_MAX_W-1:0] new_w,
        input logic [DMEM_MAX_B-1:0] be
    );
        logic [DMEM_MAX_W-1:0] r;
        r = old_w;
        for (int k = 0; k < DMEM_MAX_B; k++) begin
            if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_init_sweeper.sv
// Post-reset initialisation sweep: walks every implemented word address once,
// one word per cycle, then parks in IDLE and reports memReady.
module dmem_init_sweeper
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int ADDR_WIDTH        = 8,
    parameter int LOWER_DMEM_LIMIT  = 0,
    parameter int HIGHER_DMEM_LIMIT = 255,
    parameter int INIT_MODE         = INIT_INDEX
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  initWrEn,
    output logic [ADDR_WIDTH-1:0] initAddr,
    output logic [DATA_WIDTH-1:0] initData,
    output logic                  memReady
);

    localparam logic [ADDR_WIDTH-1:0] LO_A = ADDR_WIDTH'(LOWER_DMEM_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] HI_A = ADDR_WIDTH'(HIGHER_DMEM_LIMIT);

    dmem_state_e           state_q;
    logic [ADDR_WIDTH-1:0] initPtr_q;
    logic                  ready_q;

    // FSM: INIT sweeps LO..HI, leaving on the cycle that writes HI; IDLE holds until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INIT;
            initPtr_q <= LO_A;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    initPtr_q <= initPtr_q + 1'b1;
                    if (initPtr_q == HI_A) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign initWrEn = (state_q == INIT);
    assign initAddr = initPtr_q;
    assign memReady = ready_q;

    // Fill word: the address zero-extended or truncated, or all zeros.
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_fill
        if (INIT_MODE == INIT_INDEX && i < ADDR_WIDTH) begin : g_idx
            assign initData[i] = initPtr_q[i];
        end else begin : g_zero
            assign initData[i] = 1'b0;
        end
    end

endmodule

// File: rtl/data_memory_sweep.sv
// Parametrised data memory with byte strobes, registered reads, range check
// and a post-reset initialisation sweep that gates user access.
module data_memory_sweep
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int ADDR_WIDTH        = 8,
    parameter int LOWER_DMEM_LIMIT  = 0,
    parameter int HIGHER_DMEM_LIMIT = 255,
    parameter int INIT_MODE         = INIT_INDEX
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sigMemRead,
    input  logic                    sigMemWrite,
    input  logic [ADDR_WIDTH-1:0]   dataAddress,
    input  logic [DATA_WIDTH-1:0]   writeData,
    input  logic [DATA_WIDTH/8-1:0] byteEnable,
    output logic [DATA_WIDTH-1:0]   readData,
    output logic                    readValid,
    output logic                    memReady,
    output logic                    addrError
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int DEPTH = HIGHER_DMEM_LIMIT - LOWER_DMEM_LIMIT + 1;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_WIDTH-1:0] LO_A = ADDR_WIDTH'(LOWER_DMEM_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] HI_A = ADDR_WIDTH'(HIGHER_DMEM_LIMIT);

    // Array is indexed by offset from LOWER_DMEM_LIMIT.
    logic [DATA_WIDTH-1:0] mem_q [2**IW];

    logic                  initWrEn;
    logic [ADDR_WIDTH-1:0] initAddr;
    logic [DATA_WIDTH-1:0] initData;

    logic                  readValid_q;
    logic                  addrError_q;
    logic [DATA_WIDTH-1:0] readData_q;

    dmem_init_sweeper #(
        .DATA_WIDTH       (DATA_WIDTH),
        .ADDR_WIDTH       (ADDR_WIDTH),
        .LOWER_DMEM_LIMIT (LOWER_DMEM_LIMIT),
        .HIGHER_DMEM_LIMIT(HIGHER_DMEM_LIMIT),
        .INIT_MODE        (INIT_MODE)
    ) u_sweeper (
        .clk     (clk),
        .reset   (reset),
        .initWrEn(initWrEn),
        .initAddr(initAddr),
        .initData(initData),
        .memReady(memReady)
    );

    // Range check by borrow bits, which avoids constant-folded compares
    // when a limit sits at the edge of the address space.
    logic                  belowLo;
    logic                  aboveHi;
    logic [ADDR_WIDTH-1:0] userOff;
    logic [ADDR_WIDTH-1:0] hiDiff;
    logic [ADDR_WIDTH-1:0] initOff;
    logic                  inRange;

    assign {belowLo, userOff} = {1'b0, dataAddress} - {1'b0, LO_A};
    assign {aboveHi, hiDiff}  = {1'b0, HI_A} - {1'b0, dataAddress};
    assign initOff            = initAddr - LO_A;
    assign inRange            = !belowLo && !aboveHi;

    logic [IW-1:0] userIdx;
    logic [IW-1:0] initIdx;
    assign userIdx = userOff[IW-1:0];
    assign initIdx = initOff[IW-1:0];

    // Strobed merge of the user write into the currently stored word.
    logic [DMEM_MAX_W-1:0] oldExt;
    logic [DMEM_MAX_W-1:0] newExt;
    logic [DMEM_MAX_B-1:0] beExt;
    logic [DMEM_MAX_W-1:0] mergedExt;

    // Zero-extend the operands to the helper's fixed width.
    always_comb begin
        oldExt                 = '0;
        newExt                 = '0;
        beExt                  = '0;
        oldExt[DATA_WIDTH-1:0] = mem_q[userIdx];
        newExt[DATA_WIDTH-1:0] = writeData;
        beExt[BE_W-1:0]        = byteEnable;
    end

    assign mergedExt = byte_merge(oldExt, newExt, beExt);

    // Write port mux: the sweeper owns the array until memReady; the two
    // never overlap because user writes require memReady.
    logic                  userWr;
    logic                  wrEn;
    logic [IW-1:0]         wrIdx;
    logic [DATA_WIDTH-1:0] wrWord;

    assign userWr = !reset && memReady && sigMemWrite && inRange;

    // Select between sweep fill and merged user write.
    always_comb begin
        wrEn   = userWr || (!reset && initWrEn);
        wrIdx  = userIdx;
        wrWord = mergedExt[DATA_WIDTH-1:0];
        if (initWrEn) begin
            wrIdx  = initIdx;
            wrWord = initData;
        end
    end

    // Array storage; reset only restarts the sweep, it never clears in one cycle.
    always_ff @(posedge clk) begin
        if (wrEn) mem_q[wrIdx] <= wrWord;
    end

    // Registered read, valid pulse and range-error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            readData_q  <= '0;
            readValid_q <= 1'b0;
            addrError_q <= 1'b0;
        end else begin
            readValid_q <= 1'b0;
            addrError_q <= 1'b0;
            if (memReady) begin
                if (inRange) begin
                    if (sigMemRead) begin
                        readData_q  <= mem_q[userIdx];
                        readValid_q <= 1'b1;
                    end
                end else if (sigMemRead || sigMemWrite) begin
                    addrError_q <= 1'b1;
                    if (sigMemRead) begin
                        readData_q  <= '0;
                        readValid_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign readData  = readData_q;
    assign readValid = readValid_q;
    assign addrError = addrError_q;

    // Bits of the offset arithmetic and merge width that are not needed.
    logic unusedBits;
    assign unusedBits = ^{hiDiff, userOff, initOff, mergedExt};

endmodule

// File: tb/tb_data_memory_sweep.sv
// Directed bench: four configurations of data_memory_sweep checked against
// hand-computed expected values.
module tb_data_memory_sweep;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance stimulus: 0=default, 1=16-bit word, 2=window 16..31, 3=zero fill.
    logic [3:0]       rst;
    logic [3:0]       rdq;
    logic [3:0]       wrq;
    logic [3:0][7:0]  addr;
    logic [3:0][15:0] wd;
    logic [3:0][1:0]  be;

    logic [7:0]  rd0, rd2, rd3;
    logic [15:0] rd1;
    logic [3:0]  rv, rdy, ae;

    int n_cmp = 0;
    int n_mis = 0;

    data_memory_sweep u_d0 (
        .clk(clk), .reset(rst[0]), .sigMemRead(rdq[0]), .sigMemWrite(wrq[0]),
        .dataAddress(addr[0]), .writeData(wd[0][7:0]), .byteEnable(be[0][0:0]),
        .readData(rd0), .readValid(rv[0]), .memReady(rdy[0]), .addrError(ae[0]));

    data_memory_sweep #(.DATA_WIDTH(16)) u_d1 (
        .clk(clk), .reset(rst[1]), .sigMemRead(rdq[1]), .sigMemWrite(wrq[1]),
        .dataAddress(addr[1]), .writeData(wd[1]), .byteEnable(be[1]),
        .readData(rd1), .readValid(rv[1]), .memReady(rdy[1]), .addrError(ae[1]));

    data_memory_sweep #(.LOWER_DMEM_LIMIT(16), .HIGHER_DMEM_LIMIT(31)) u_d2 (
        .clk(clk), .reset(rst[2]), .sigMemRead(rdq[2]), .sigMemWrite(wrq[2]),
        .dataAddress(addr[2]), .writeData(wd[2][7:0]), .byteEnable(be[2][0:0]),
        .readData(rd2), .readValid(rv[2]), .memReady(rdy[2]), .addrError(ae[2]));

    data_memory_sweep #(.INIT_MODE(1)) u_d3 (
        .clk(clk), .reset(rst[3]), .sigMemRead(rdq[3]), .sigMemWrite(wrq[3]),
        .dataAddress(addr[3]), .writeData(wd[3][7:0]), .byteEnable(be[3][0:0]),
        .readData(rd3), .readValid(rv[3]), .memReady(rdy[3]), .addrError(ae[3]));

    function automatic logic [15:0] rdat(input int d);
        case (d)
            0:       return {8'h00, rd0};
            1:       return rd1;
            2:       return {8'h00, rd2};
            default: return {8'h00, rd3};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // One request cycle: drive at negedge, sample results at the next negedge.
    task automatic op(input int d, input logic r, input logic w, input logic [7:0] a,
                      input logic [15:0] dat, input logic [1:0] b);
        rdq[d] = r; wrq[d] = w; addr[d] = a; wd[d] = dat; be[d] = b;
        @(negedge clk);
        rdq[d] = 1'b0; wrq[d] = 1'b0;
    endtask

    // Count cycles with memReady low starting at the cycle reset drops.
    task automatic wait_ready(input int d, output int cnt);
        cnt = 0;
        while (!rdy[d] && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    int cnt;
    int bad;

    initial begin
        rst = '1; rdq = '0; wrq = '0; addr = '0; wd = '0; be = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(rdy[0]), 0);
        chk("rst_valid", 32'(rv[0]), 0);
        chk("rst_aerr",  32'(ae[0]), 0);
        chk("rst_rdata", 32'(rd0), 0);

        // Release all; hammer instance 0 with requests throughout its sweep.
        rst = '0;
        cnt = 0; bad = 0;
        while (!rdy[0] && cnt < 1000) begin
            rdq[0] = 1'b1; wrq[0] = 1'b1; addr[0] = cnt[7:0]; wd[0] = 16'h00FF; be[0] = 2'b01;
            @(negedge clk);
            cnt++;
            if (rv[0] || ae[0]) bad++;
        end
        rdq[0] = 1'b0; wrq[0] = 1'b0;
        chk("sweep_len", 32'(cnt), 256);
        chk("init_ignored", 32'(bad), 0);

        // Fill pattern survived the ignored writes; latency 1, valid one cycle.
        op(0, 1, 0, 8'h03, 0, 0);
        chk("fill_03", 32'(rd0), 32'h03);
        op(0, 1, 0, 8'h2A, 0, 0);
        chk("rd2a_valid", 32'(rv[0]), 1);
        chk("rd2a_data", 32'(rd0), 32'h2A);
        @(negedge clk);
        chk("rd2a_drop", 32'(rv[0]), 0);
        chk("rd2a_hold", 32'(rd0), 32'h2A);
        op(0, 1, 0, 8'hFF, 0, 0);
        chk("fill_ff", 32'(rd0), 32'hFF);

        // Read-before-write on the same address.
        op(0, 1, 1, 8'h07, 16'h0099, 2'b01);
        chk("raw_old", 32'(rd0), 32'h07);
        op(0, 1, 0, 8'h07, 0, 0);
        chk("raw_new", 32'(rd0), 32'h99);

        // Back-to-back reads, no bubbles.
        rdq[0] = 1'b1; addr[0] = 8'h10;
        @(negedge clk);
        chk("b2b0_v", 32'(rv[0]), 1); chk("b2b0_d", 32'(rd0), 32'h10);
        addr[0] = 8'h11;
        @(negedge clk);
        chk("b2b1_v", 32'(rv[0]), 1); chk("b2b1_d", 32'(rd0), 32'h11);
        addr[0] = 8'h12;
        @(negedge clk);
        chk("b2b2_v", 32'(rv[0]), 1); chk("b2b2_d", 32'(rd0), 32'h12);
        rdq[0] = 1'b0;

        // 16-bit strobes.
        op(1, 0, 1, 8'h05, 16'hBEEF, 2'b10);
        op(1, 1, 0, 8'h05, 0, 0);
        chk("be_hi", 32'(rd1), 32'hBE05);
        op(1, 0, 1, 8'h06, 16'hBEEF, 2'b00);
        op(1, 1, 0, 8'h06, 0, 0);
        chk("be_none", 32'(rd1), 32'h0006);
        op(1, 0, 1, 8'h08, 16'h1234, 2'b01);
        op(1, 1, 0, 8'h08, 0, 0);
        chk("be_lo", 32'(rd1), 32'h0034);

        // Address window 16..31.
        op(2, 1, 0, 8'd16, 0, 0);
        chk("win_lo", 32'(rd2), 32'h10);
        op(2, 1, 0, 8'd31, 0, 0);
        chk("win_hi", 32'(rd2), 32'h1F);
        op(2, 0, 1, 8'd40, 16'h00AA, 2'b01);
        chk("oorw_aerr", 32'(ae[2]), 1);
        chk("oorw_valid", 32'(rv[2]), 0);
        chk("oorw_hold", 32'(rd2), 32'h1F);
        @(negedge clk);
        chk("oorw_drop", 32'(ae[2]), 0);
        op(2, 1, 0, 8'd40, 0, 0);
        chk("oorr_aerr", 32'(ae[2]), 1);
        chk("oorr_valid", 32'(rv[2]), 1);
        chk("oorr_data", 32'(rd2), 0);
        op(2, 1, 0, 8'd15, 0, 0);
        chk("below_aerr", 32'(ae[2]), 1);
        op(2, 1, 0, 8'd16, 0, 0);
        chk("win_ok_aerr", 32'(ae[2]), 0);
        chk("win_ok_data", 32'(rd2), 32'h10);

        // Zero fill, dirty, then reset twice with a restart at sweep cycle 100.
        op(3, 1, 0, 8'd200, 0, 0);
        chk("zfill_200", 32'(rd3), 0);
        op(3, 0, 1, 8'd200, 16'h0055, 2'b01);
        op(3, 1, 0, 8'd200, 0, 0);
        chk("dirty_200", 32'(rd3), 32'h55);
        rst[3] = 1'b1;
        @(negedge clk);
        rst[3] = 1'b0;
        repeat (100) @(negedge clk);
        chk("mid_notready", 32'(rdy[3]), 0);
        rst[3] = 1'b1;
        @(negedge clk);
        chk("rerst_valid", 32'(rv[3]), 0);
        rst[3] = 1'b0;
        wait_ready(3, cnt);
        chk("resweep_len", 32'(cnt), 256);
        op(3, 1, 0, 8'd200, 0, 0);
        chk("resweep_200", 32'(rdat(3)), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
